// File: rtl/frogger_pkg.sv
// Shared definitions for the lane traffic controller and its lane movers:
// FSM encoding, lane type and direction constants, default geometry and
// the level-scaled period helper.
package frogger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  localparam logic LANE_CAR  = 1'b0;
  localparam logic LANE_LOG  = 1'b1;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  localparam int DEF_COORD_W = 6;
  localparam int DEF_MAX_X   = 14;

  // Higher levels halve the step period per level step.
  function automatic logic [31:0] lane_period(input logic [31:0] base,
                                              input logic [1:0]  level);
    return base >> level;
  endfunction

endpackage

// File: rtl/lane_mover.sv
// One obstacle lane: step counter, position register and wrap logic.
// Emits a combinational step pulse in the cycle whose clock edge moves
// the obstacle, so the parent can line carry pulses up with the move.
module lane_mover
  import frogger_pkg::*;
#(
  parameter int          COORD_W = DEF_COORD_W,
  parameter int          MAX_X   = DEF_MAX_X,
  parameter logic [31:0] PERIOD  = 32'd4000000,
  parameter logic        DIR     = DIR_RIGHT,
  parameter int          INIT_X  = 0
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               run,
  input  logic [1:0]         level,
  output logic [COORD_W-1:0] pos,
  output logic               step
);

  localparam logic [COORD_W-1:0] LAST_X  = COORD_W'(MAX_X - 1);
  localparam logic [COORD_W-1:0] START_X = COORD_W'(INIT_X);
  localparam logic [COORD_W-1:0] ONE_X   = COORD_W'(1);

  logic [31:0]        cnt;
  logic [31:0]        period;
  logic [31:0]        limit;
  logic [COORD_W-1:0] next_pos;

  // Step decision against the current level's period, and wrapped next position.
  always_comb begin
    period   = lane_period(PERIOD, level);
    limit    = (period == 32'd0) ? 32'd0 : period - 32'd1;
    step     = run && (cnt >= limit);
    next_pos = pos;
    if (DIR == DIR_LEFT) begin
      next_pos = (pos == '0) ? LAST_X : pos - ONE_X;
    end else begin
      next_pos = (pos >= LAST_X) ? '0 : pos + ONE_X;
    end
  end

  // Counter and position: clear-and-move on step, count while running, else hold.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      cnt <= '0;
      pos <= START_X;
    end else if (step) begin
      cnt <= '0;
      pos <= next_pos;
    end else if (run) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/lane_traffic_ctrl.sv
// Multi-lane obstacle controller: moves N_LANES cars/logs, resolves frog
// collision / drowning / log carry, and answers per-tile scan lookups.
// Optional build macro LONG_OBJECT_EN: each obstacle covers its head tile
// plus the tile behind it (relative to motion, wrapping).
module lane_traffic_ctrl
  import frogger_pkg::*;
#(
  parameter int                 N_LANES       = 5,
  parameter int                 COORD_W       = DEF_COORD_W,
  parameter int                 MAX_X         = DEF_MAX_X,
  parameter int                 FIRST_ROW     = 7,
  parameter logic [31:0]        BASE_PERIOD   = 32'd4000000,
  parameter logic [31:0]        LANE_DELTA    = 32'd300000,
  parameter logic [N_LANES-1:0] DIR_MASK      = 5'b01010,
  parameter logic [N_LANES-1:0] LOG_MASK      = 5'b00000,
  parameter logic [31:0]        FREEZE_CYCLES = 32'd25000000
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst_L,
  input  logic                       i_Enable,
  input  logic [1:0]                 i_Level,
  input  logic [COORD_W-1:0]         i_Frog_X,
  input  logic [COORD_W-1:0]         i_Frog_Y,
  input  logic [COORD_W-1:0]         i_Scan_X,
  input  logic [COORD_W-1:0]         i_Scan_Y,
  output logic [N_LANES*COORD_W-1:0] o_Obj_X,
  output logic                       o_Scan_Hit,
  output logic                       o_Scan_Is_Log,
  output logic                       o_Collided,
  output logic                       o_On_Log,
  output logic                       o_Carry_L,
  output logic                       o_Carry_R,
  output logic [1:0]                 o_State
);

  localparam logic [31:0] FREEZE_LAST =
    (FREEZE_CYCLES == 32'd0) ? 32'd0 : FREEZE_CYCLES - 32'd1;

  state_t             state;
  state_t             state_nx;
  logic [31:0]        frz_cnt;
  logic               run;
  logic               hit_entry;

  logic [COORD_W-1:0] lane_x [N_LANES];
  logic [N_LANES-1:0] lane_step;
  logic [N_LANES-1:0] frog_row;
  logic [N_LANES-1:0] frog_cover;
  logic [N_LANES-1:0] scan_row;
  logic [N_LANES-1:0] scan_cover;

  logic               collide_c;
  logic               on_log_c;
  logic               carry_l_c;
  logic               carry_r_c;
  logic               scan_hit_c;
  logic               scan_log_c;

  // Lanes only advance while running and the game is enabled in this very cycle.
  assign run     = (state == ST_RUN) && i_Enable;
  assign o_State = state;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    localparam logic [31:0] PERIOD_K = BASE_PERIOD + LANE_DELTA * 32'(k);
    localparam int          INIT_K   = (k * 3) % MAX_X;

    lane_mover #(
      .COORD_W (COORD_W),
      .MAX_X   (MAX_X),
      .PERIOD  (PERIOD_K),
      .DIR     (DIR_MASK[k]),
      .INIT_X  (INIT_K)
    ) u_mover (
      .clk   (i_Clk),
      .rst_l (i_Rst_L),
      .run   (run),
      .level (i_Level),
      .pos   (lane_x[k]),
      .step  (lane_step[k])
    );

    assign o_Obj_X[k*COORD_W +: COORD_W] = lane_x[k];

    if (FIRST_ROW - k >= 0) begin : g_row
      localparam logic [COORD_W-1:0] ROW_K = COORD_W'(FIRST_ROW - k);
      assign frog_row[k] = (i_Frog_Y == ROW_K);
      assign scan_row[k] = (i_Scan_Y == ROW_K);
    end else begin : g_norow
      assign frog_row[k] = 1'b0;
      assign scan_row[k] = 1'b0;
    end

`ifdef LONG_OBJECT_EN
    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(MAX_X - 1);
    localparam logic [COORD_W-1:0] ONE_X  = COORD_W'(1);
    logic [COORD_W-1:0] tail;
    // Tail trails the head: right-movers trail on the left, left-movers on the right.
    assign tail = (DIR_MASK[k] == DIR_LEFT)
                ? ((lane_x[k] >= LAST_X) ? '0 : lane_x[k] + ONE_X)
                : ((lane_x[k] == '0) ? LAST_X : lane_x[k] - ONE_X);
    assign frog_cover[k] = (i_Frog_X == lane_x[k]) || (i_Frog_X == tail);
    assign scan_cover[k] = (i_Scan_X == lane_x[k]) || (i_Scan_X == tail);
`else
    assign frog_cover[k] = (i_Frog_X == lane_x[k]);
    assign scan_cover[k] = (i_Scan_X == lane_x[k]);
`endif
  end

  // Frog versus obstacles: car hit, drown off a log, ride and carry on a log.
  always_comb begin
    collide_c = 1'b0;
    on_log_c  = 1'b0;
    carry_l_c = 1'b0;
    carry_r_c = 1'b0;
    for (int k = 0; k < N_LANES; k++) begin
      if (frog_row[k]) begin
        if (LOG_MASK[k] == LANE_LOG) begin
          if (frog_cover[k]) begin
            on_log_c = 1'b1;
            if (lane_step[k]) begin
              if (DIR_MASK[k] == DIR_LEFT) carry_l_c = 1'b1;
              else                         carry_r_c = 1'b1;
            end
          end else begin
            collide_c = 1'b1;
          end
        end else if (frog_cover[k]) begin
          collide_c = 1'b1;
        end
      end
    end
    if (collide_c) begin
      carry_l_c = 1'b0;
      carry_r_c = 1'b0;
    end
  end

  // Scan lookup; walking from the top lane down lets the lowest index win.
  always_comb begin
    scan_hit_c = 1'b0;
    scan_log_c = 1'b0;
    for (int k = N_LANES - 1; k >= 0; k--) begin
      if (scan_row[k] && scan_cover[k]) begin
        scan_hit_c = 1'b1;
        scan_log_c = LOG_MASK[k];
      end
    end
  end

  // Next-state logic; disable forces IDLE from anywhere.
  always_comb begin
    state_nx  = state;
    hit_entry = 1'b0;
    if (!i_Enable) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   state_nx = ST_RUN;
        ST_RUN: begin
          if (collide_c) begin
            state_nx  = ST_FROZEN;
            hit_entry = 1'b1;
          end
        end
        ST_FROZEN: if (frz_cnt >= FREEZE_LAST) state_nx = ST_RUN;
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  // State register plus freeze timer that only runs while staying FROZEN.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state   <= ST_IDLE;
      frz_cnt <= '0;
    end else begin
      state   <= state_nx;
      if ((state == ST_FROZEN) && (state_nx == ST_FROZEN)) frz_cnt <= frz_cnt + 32'd1;
      else                                                  frz_cnt <= '0;
    end
  end

  // Registered result outputs, one cycle behind their inputs.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      o_Collided    <= 1'b0;
      o_On_Log      <= 1'b0;
      o_Carry_L     <= 1'b0;
      o_Carry_R     <= 1'b0;
      o_Scan_Hit    <= 1'b0;
      o_Scan_Is_Log <= 1'b0;
    end else begin
      o_Collided    <= hit_entry;
      o_On_Log      <= on_log_c;
      o_Carry_L     <= carry_l_c;
      o_Carry_R     <= carry_r_c;
      o_Scan_Hit    <= scan_hit_c;
      o_Scan_Is_Log <= scan_log_c;
    end
  end

endmodule

// File: tb/tb_lane_traffic_ctrl.sv
// Directed bench for lane_traffic_ctrl with short periods: lane period 10,
// freeze 20, lanes 1 and 3 left-moving, lane 2 (row 5) a log lane.
module tb_lane_traffic_ctrl;

  localparam int N  = 5;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_l;
  logic          en;
  logic [1:0]    level;
  logic [CW-1:0] frog_x, frog_y, scan_x, scan_y;
  logic [N*CW-1:0] obj_x;
  logic          scan_hit, scan_log, collided, on_log, carry_l, carry_r;
  logic [1:0]    st;

  int total = 0;
  int bad   = 0;

  lane_traffic_ctrl #(
    .N_LANES       (N),
    .COORD_W       (CW),
    .MAX_X         (14),
    .FIRST_ROW     (7),
    .BASE_PERIOD   (32'd10),
    .LANE_DELTA    (32'd0),
    .DIR_MASK      (5'b01010),
    .LOG_MASK      (5'b00100),
    .FREEZE_CYCLES (32'd20)
  ) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_l),
    .i_Enable      (en),
    .i_Level       (level),
    .i_Frog_X      (frog_x),
    .i_Frog_Y      (frog_y),
    .i_Scan_X      (scan_x),
    .i_Scan_Y      (scan_y),
    .o_Obj_X       (obj_x),
    .o_Scan_Hit    (scan_hit),
    .o_Scan_Is_Log (scan_log),
    .o_Collided    (collided),
    .o_On_Log      (on_log),
    .o_Carry_L     (carry_l),
    .o_Carry_R     (carry_r),
    .o_State       (st)
  );

  always #5 clk = ~clk;

  function automatic logic [N*CW-1:0] pk(input int a0, input int a1, input int a2,
                                         input int a3, input int a4);
    return {CW'(a4), CW'(a3), CW'(a2), CW'(a1), CW'(a0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_l = 1'b0; en = 1'b0; level = 2'd0;
    frog_x = 6'd0; frog_y = 6'd10; scan_x = 6'd0; scan_y = 6'd10;
    tick();
    rst_l = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (obj_x !== pk(0, 3, 6, 9, 12)) begin bad++; $display("FAIL reset_obj got=%h want=%h", obj_x, pk(0, 3, 6, 9, 12)); end
    total++; if (st !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", st); end
    total++; if ({collided, on_log, carry_l, carry_r, scan_hit, scan_log} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=000000", {collided, on_log, carry_l, carry_r, scan_hit, scan_log});
    end
  endtask

  task automatic test_step_and_wrap();
    do_reset();
    en = 1'b1;
    tick();
    total++; if (st !== 2'd1) begin bad++; $display("FAIL run_state got=%0d want=1", st); end
    ticks(9);
    total++; if (obj_x !== pk(0, 3, 6, 9, 12)) begin bad++; $display("FAIL pre_step got=%h want=%h", obj_x, pk(0, 3, 6, 9, 12)); end
    tick();
    total++; if (obj_x !== pk(1, 2, 7, 8, 13)) begin bad++; $display("FAIL step1 got=%h want=%h", obj_x, pk(1, 2, 7, 8, 13)); end
    ticks(10);
    total++; if (obj_x !== pk(2, 1, 8, 7, 0)) begin bad++; $display("FAIL wrap_right got=%h want=%h", obj_x, pk(2, 1, 8, 7, 0)); end
    ticks(10);
    total++; if (obj_x !== pk(3, 0, 9, 6, 1)) begin bad++; $display("FAIL step3 got=%h want=%h", obj_x, pk(3, 0, 9, 6, 1)); end
    ticks(10);
    total++; if (obj_x !== pk(4, 13, 10, 5, 2)) begin bad++; $display("FAIL wrap_left got=%h want=%h", obj_x, pk(4, 13, 10, 5, 2)); end
  endtask

  task automatic test_enable_hold();
    do_reset();
    en = 1'b1;
    tick();
    ticks(5);
    en = 1'b0;
    tick();
    total++; if (st !== 2'd0) begin bad++; $display("FAIL disable_state got=%0d want=0", st); end
    ticks(10);
    total++; if (obj_x !== pk(0, 3, 6, 9, 12)) begin bad++; $display("FAIL disable_hold got=%h want=%h", obj_x, pk(0, 3, 6, 9, 12)); end
    en = 1'b1;
    tick();
    ticks(4);
    total++; if (obj_x[CW-1:0] !== 6'd0) begin bad++; $display("FAIL resume_early got=%0d want=0", obj_x[CW-1:0]); end
    tick();
    total++; if (obj_x[CW-1:0] !== 6'd1) begin bad++; $display("FAIL resume_step got=%0d want=1", obj_x[CW-1:0]); end
  endtask

  task automatic test_collision();
    do_reset();
    frog_x = 6'd1; frog_y = 6'd7;
    en = 1'b1;
    tick();
    ticks(9);
    tick();
    total++; if (collided !== 1'b0 || obj_x[CW-1:0] !== 6'd1) begin
      bad++; $display("FAIL collide_early got=%b/%0d want=0/1", collided, obj_x[CW-1:0]);
    end
    tick();
    total++; if (collided !== 1'b1) begin bad++; $display("FAIL collide_pulse got=%b want=1", collided); end
    total++; if (st !== 2'd2) begin bad++; $display("FAIL frozen_state got=%0d want=2", st); end
    tick();
    total++; if (collided !== 1'b0) begin bad++; $display("FAIL collide_once got=%b want=0", collided); end
    frog_y = 6'd10;
    ticks(18);
    total++; if (st !== 2'd2) begin bad++; $display("FAIL freeze_len got=%0d want=2", st); end
    total++; if (obj_x !== pk(1, 2, 7, 8, 13)) begin bad++; $display("FAIL freeze_hold got=%h want=%h", obj_x, pk(1, 2, 7, 8, 13)); end
    tick();
    total++; if (st !== 2'd1) begin bad++; $display("FAIL thaw_state got=%0d want=1", st); end
  endtask

  task automatic test_carry();
    do_reset();
    frog_x = 6'd6; frog_y = 6'd5;
    en = 1'b1;
    tick();
    total++; if (on_log !== 1'b1) begin bad++; $display("FAIL on_log got=%b want=1", on_log); end
    ticks(9);
    total++; if (carry_r !== 1'b0 || collided !== 1'b0) begin bad++; $display("FAIL carry_early got=%b%b want=00", carry_r, collided); end
    tick();
    total++; if ({carry_r, carry_l, collided} !== 3'b100) begin
      bad++; $display("FAIL carry_r got=%b want=100", {carry_r, carry_l, collided});
    end
    total++; if (obj_x[2*CW +: CW] !== 6'd7) begin bad++; $display("FAIL log_pos got=%0d want=7", obj_x[2*CW +: CW]); end
    tick();
    total++; if ({collided, carry_r, on_log} !== 3'b100) begin
      bad++; $display("FAIL drown got=%b want=100", {collided, carry_r, on_log});
    end
    total++; if (st !== 2'd2) begin bad++; $display("FAIL drown_state got=%0d want=2", st); end
  endtask

  task automatic test_level();
    do_reset();
    en = 1'b1;
    tick();
    ticks(5);
    level = 2'd2;
    tick();
    total++; if (obj_x[CW-1:0] !== 6'd1) begin bad++; $display("FAIL level_jump got=%0d want=1", obj_x[CW-1:0]); end
    tick();
    total++; if (obj_x[CW-1:0] !== 6'd1) begin bad++; $display("FAIL level_gap got=%0d want=1", obj_x[CW-1:0]); end
    tick();
    total++; if (obj_x !== pk(2, 1, 8, 7, 0)) begin bad++; $display("FAIL level_p2 got=%h want=%h", obj_x, pk(2, 1, 8, 7, 0)); end
    ticks(2);
    total++; if (obj_x !== pk(3, 0, 9, 6, 1)) begin bad++; $display("FAIL level_p2b got=%h want=%h", obj_x, pk(3, 0, 9, 6, 1)); end
    level = 2'd0;
  endtask

  task automatic test_scan_and_reset();
    do_reset();
    scan_x = 6'd3; scan_y = 6'd6;
    tick();
    total++; if ({scan_hit, scan_log} !== 2'b10) begin bad++; $display("FAIL scan_car got=%b want=10", {scan_hit, scan_log}); end
    scan_x = 6'd6; scan_y = 6'd5;
    tick();
    total++; if ({scan_hit, scan_log} !== 2'b11) begin bad++; $display("FAIL scan_log got=%b want=11", {scan_hit, scan_log}); end
    scan_x = 6'd4; scan_y = 6'd6;
    tick();
    total++; if (scan_hit !== 1'b0) begin bad++; $display("FAIL scan_miss got=%b want=0", scan_hit); end
    scan_x = 6'd3; scan_y = 6'd9;
    tick();
    total++; if (scan_hit !== 1'b0) begin bad++; $display("FAIL scan_norow got=%b want=0", scan_hit); end
    scan_x = 6'd12; scan_y = 6'd3;
    tick();
    total++; if ({scan_hit, scan_log} !== 2'b10) begin bad++; $display("FAIL scan_top got=%b want=10", {scan_hit, scan_log}); end
    en = 1'b1;
    tick();
    ticks(12);
    frog_x = 6'd7; frog_y = 6'd5; scan_x = 6'd7; scan_y = 6'd5;
    tick();
    total++; if ({on_log, scan_hit, scan_log, collided} !== 4'b1110) begin
      bad++; $display("FAIL mid_run got=%b want=1110", {on_log, scan_hit, scan_log, collided});
    end
    rst_l = 1'b0;
    tick();
    total++; if (obj_x !== pk(0, 3, 6, 9, 12) || st !== 2'd0) begin
      bad++; $display("FAIL rerst_obj got=%h/%0d want=%h/0", obj_x, st, pk(0, 3, 6, 9, 12));
    end
    total++; if ({collided, on_log, carry_l, carry_r, scan_hit, scan_log} !== 6'b0) begin
      bad++; $display("FAIL rerst_flags got=%b want=000000", {collided, on_log, carry_l, carry_r, scan_hit, scan_log});
    end
    rst_l = 1'b1;
  endtask

  initial begin
    test_reset();
    test_step_and_wrap();
    test_enable_hold();
    test_collision();
    test_carry();
    test_level();
    test_scan_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
